// File: rtl/immu_line_server.sv
// Instruction-fetch line server: assembles a 256-bit ICache line from eight
// 1-cycle-latency BRAM word reads; unmapped addresses return a zero line with error.
module immu_line_server #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFC000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              immu_read,
    input  logic [31:0]       immu_addr,
    output logic              immu_done,
    output logic [255:0]      immu_read_data,
    output logic              immu_err,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-4:0]   off_q;
    logic                err_q;
    logic [3:0]          iss_q;
    logic [3:0]          cap_q;
    logic [7:0][31:0]    line_q;
    logic                in_range;
    logic                accept;
    logic                issue;
    logic                capture;
    logic                unused_addr;

    assign in_range    = (immu_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign accept      = (state_q == IDLE) && immu_read;
    assign unused_addr = ^immu_addr[4:0];

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture trails issue by one cycle; the eighth capture ends the fill.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (immu_read) begin
                    state_d = in_range ? FILL : DONE;
                end
            end
            FILL: begin
                issue   = !iss_q[3];
                capture = (cap_q != iss_q);
                if (capture && (cap_q == 4'd7)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            off_q  <= '0;
            err_q  <= 1'b0;
            iss_q  <= '0;
            cap_q  <= '0;
            line_q <= '0;
        end else begin
            if (accept) begin
                off_q <= immu_addr[ADDR_W+1:5];
                err_q <= !in_range;
                iss_q <= '0;
                cap_q <= '0;
                if (!in_range) begin
                    line_q <= '0;
                end
            end
            if (issue) begin
                iss_q <= iss_q + 4'd1;
            end
            if (capture) begin
                line_q[cap_q[2:0]] <= mem_rdata;
                cap_q              <= cap_q + 4'd1;
            end
        end
    end

    assign mem_en         = issue;
    assign mem_addr       = issue ? {off_q, iss_q[2:0]} : '0;
    assign immu_done      = (state_q == DONE);
    assign immu_err       = (state_q == DONE) && err_q;
    assign busy           = (state_q != IDLE);
    assign immu_read_data = line_q;

endmodule

// File: tb/tb_immu_line_server.sv
// Bench for immu_line_server: directed scenarios plus random requests,
// checked every cycle against a latency/line model of the server.
module tb_immu_line_server;

    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'hFFFFC000;

    logic          sys_clk;
    logic          rst_n;
    logic          immu_read;
    logic [31:0]   immu_addr;
    logic          immu_done;
    logic [255:0]  immu_read_data;
    logic          immu_err;
    logic          busy;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    immu_line_server #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .immu_read      (immu_read),
        .immu_addr      (immu_addr),
        .immu_done      (immu_done),
        .immu_read_data (immu_read_data),
        .immu_err       (immu_err),
        .busy           (busy),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge sys_clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: an accepted request finishes `lat` cycles later; an
    // in-range line reads words lw..lw+7 during its first eight cycles.
    bit              m_act = 1'b0;
    int              m_age = 0;
    int              m_lat = 0;
    bit              m_inr = 1'b0;
    bit              m_err = 1'b0;
    int              m_lw  = 0;
    logic [255:0]    m_line = '0;
    logic [255:0]    last_line = '0;
    longint unsigned ma, mb;
    logic            e_en;
    logic            e_done;

    always @(posedge sys_clk) begin
        cyc++;
        if (!rst_n) begin
            m_act     = 1'b0;
            last_line = '0;
        end else if (m_act) begin
            if (m_age == m_lat) begin
                m_act     = 1'b0;
                last_line = m_line;
            end else begin
                m_age++;
            end
        end else if (immu_read) begin
            ma    = {32'd0, immu_addr};
            mb    = {32'd0, BASE};
            m_inr = (ma >= mb) && (ma < mb + (64'd4 << AW));
            m_lw  = m_inr ? int'(((ma - mb) >> 2) & 64'hFFF8) : 0;
            m_act = 1'b1;
            m_age = 1;
            m_lat = m_inr ? 10 : 1;
            m_err = !m_inr;
            for (int k = 0; k < 8; k++)
                m_line[32*k +: 32] = m_inr ? mem[m_lw + k] : 32'd0;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_on) begin
            e_done = m_act && (m_age == m_lat);
            e_en   = m_act && m_inr && (m_age <= 8);
            chk("busy", 256'(busy), 256'(m_act));
            chk("done", 256'(immu_done), 256'(e_done));
            chk("mem_en", 256'(mem_en), 256'(e_en));
            if (e_en)
                chk("mem_addr", 256'(mem_addr), 256'(m_lw + m_age - 1));
            if (e_done) begin
                chk("err", 256'(immu_err), 256'(m_err));
                chk("line", immu_read_data, m_line);
            end else begin
                chk("err_idle", 256'(immu_err), 256'd0);
            end
            if (!m_act)
                chk("hold", immu_read_data, last_line);
        end
    end

    logic [AW-1:0] en_q [$];

    task automatic do_req(input logic [31:0] addr, input int pert,
                          output int t, output logic [255:0] d,
                          output logic e, output int dc);
        immu_addr = addr;
        immu_read = 1'b1;
        t  = 0;
        d  = '0;
        e  = 1'b0;
        dc = 0;
        while (1) begin
            @(negedge sys_clk);
            t++;
            if (mem_en) en_q.push_back(mem_addr);
            if (t == 3 && pert[0]) immu_read = 1'b0;
            if (t == 4 && pert[1]) immu_addr = $urandom;
            if (immu_done) begin
                d  = immu_read_data;
                e  = immu_err;
                dc = cyc;
                immu_read = 1'b0;
                break;
            end
            if (t > 40) begin
                n_chk++;
                n_err++;
                $display("FAIL timeout addr=%h waited=%0d", addr, t);
                immu_read = 1'b0;
                break;
            end
        end
    endtask

    int           t, dc1, dc2, n, g, dn, gap;
    logic [255:0] d, line2;
    logic         e;
    logic [31:0]  ra;

    initial begin
        rst_n     = 1'b0;
        immu_read = 1'b1;
        immu_addr = BASE + 32'h40;
        for (int w = 0; w < (1 << AW); w++) mem[w] = 32'hA000_0000 + w;

        @(posedge sys_clk);
        #1 chk_on = 1'b1;
        @(negedge sys_clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(immu_done), 256'd0);
        chk("rst_err", 256'(immu_err), 256'd0);
        chk("rst_data", immu_read_data, 256'd0);
        chk("rst_maddr", 256'(mem_addr), 256'd0);
        @(negedge sys_clk);
        chk("rst_mem_en", 256'(mem_en), 256'd0);
        rst_n     = 1'b1;
        immu_read = 1'b0;

        @(negedge sys_clk);
        en_q.delete();
        do_req(BASE + 32'h40, 0, t, d, e, dc1);
        chk("fill_lat", 256'(t), 256'd10);
        chk("fill_err", 256'(e), 256'd0);
        for (int k = 0; k < 8; k++)
            chk("fill_word", 256'(d[32*k +: 32]), 256'(32'hA000_0010 + k));
        chk("fill_nrd", 256'(en_q.size()), 256'd8);
        chk("fill_a0", 256'(en_q[0]), 256'd16);
        chk("fill_a7", 256'(en_q[7]), 256'd23);
        line2 = d;

        @(negedge sys_clk);
        do_req(BASE + 32'h5C, 0, t, d, e, dc1);
        chk("unal_lat", 256'(t), 256'd10);
        chk("unal_line", d, line2);

        @(negedge sys_clk);
        en_q.delete();
        do_req(32'h0000_8000, 0, t, d, e, dc1);
        chk("oor_lat", 256'(t), 256'd1);
        chk("oor_err", 256'(e), 256'd1);
        chk("oor_data", d, 256'd0);
        chk("oor_nrd", 256'(en_q.size()), 256'd0);

        @(negedge sys_clk);
        en_q.delete();
        do_req(BASE, 0, t, d, e, dc1);
        @(negedge sys_clk);
        do_req(BASE + 32'h20, 0, t, d, e, dc2);
        chk("b2b_gap", 256'(dc2 - dc1), 256'd11);
        chk("b2b_nrd", 256'(en_q.size()), 256'd16);
        chk("b2b_a8", 256'(en_q[8]), 256'd8);
        chk("b2b_w0", 256'(d[31:0]), 256'(32'hA000_0008));

        @(negedge sys_clk);
        immu_addr = BASE + 32'h80;
        immu_read = 1'b1;
        n = 0;
        g = 0;
        while (n < 4 && g < 20) begin
            @(negedge sys_clk);
            g++;
            if (mem_en) n++;
        end
        chk("mid_issues", 256'(n), 256'd4);
        rst_n     = 1'b0;
        immu_read = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        chk("mid_busy", 256'(busy), 256'd0);
        chk("mid_data", immu_read_data, 256'd0);
        @(negedge sys_clk);
        do_req(BASE + 32'h80, 0, t, d, e, dc1);
        chk("mid_lat", 256'(t), 256'd10);
        for (int k = 0; k < 8; k++)
            chk("mid_word", 256'(d[32*k +: 32]), 256'(32'hA000_0020 + k));
        dn = 0;
        repeat (12) begin
            @(negedge sys_clk);
            if (immu_done) dn++;
        end
        chk("mid_extra_done", 256'(dn), 256'd0);

        for (int w = 0; w < (1 << AW); w++) mem[w] = $urandom;
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge sys_clk);
            if ($urandom_range(0, 9) < 7)
                ra = BASE + $urandom_range(0, 16383);
            else
                ra = $urandom;
            do_req(ra, $urandom_range(0, 3), t, d, e, dc1);
        end
        repeat (4) @(negedge sys_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
